// File: rtl/ahb_apb_pkg.sv
// Shared encodings, response-state type and address-map defaults for the AHB-to-APB bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [1:0] {
        RESP_OK   = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_state_e;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
    localparam int          DEF_SLOT_SHIFT = 26;
    localparam int          DEF_NUM_SLOTS  = 3;
    localparam logic [4:0]  BEAT_CNT_MAX   = 5'd31;

endpackage

// File: rtl/ahb_addr_decode.sv
// Bridge address-window check and one-hot peripheral slot select (purely combinational).
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_SHIFT = DEF_SLOT_SHIFT,
    parameter int          NUM_SLOTS  = DEF_NUM_SLOTS
) (
    input  logic [31:0]          haddr,
    output logic                 in_win,
    output logic [NUM_SLOTS-1:0] tempselx
);

    localparam logic [32:0] WIN_SIZE = 33'(NUM_SLOTS) << SLOT_SHIFT;

    logic [31:0] offset;
    logic [31:0] slot;

    assign offset = haddr - BASE_ADDR;
    assign slot   = offset >> SLOT_SHIFT;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    assign in_win = (haddr >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);

    always_comb begin
        tempselx = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            tempselx[k] = in_win && (slot == 32'(k));
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: address/data pipeline, decode, burst count, response.
// Define AHB_SLV_ERR_RESP_EN to build the two-cycle ERROR response for out-of-window transfers.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_SHIFT = DEF_SLOT_SHIFT,
    parameter int          NUM_SLOTS  = DEF_NUM_SLOTS
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hwrite,
    input  logic                 hreadyin,
    input  logic [1:0]           htrans,
    input  logic [31:0]          haddr,
    input  logic [31:0]          hwdata,
    input  logic [31:0]          prdata,
    output logic                 valid,
    output logic [31:0]          haddr_1,
    output logic [31:0]          haddr_2,
    output logic [31:0]          hwdata_1,
    output logic [31:0]          hwdata_2,
    output logic                 hwrite_reg,
    output logic                 hwrite_reg_1,
    output logic [NUM_SLOTS-1:0] tempselx,
    output logic [31:0]          hrdata,
    output logic [1:0]           hresp,
    output logic                 err_stall,
    output logic [4:0]           beat_cnt
);

    logic in_win;
    logic active_phase;
    logic accept_nonseq;
    logic accept_seq;

    ahb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLOT_SHIFT(SLOT_SHIFT),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_decode (
        .haddr   (haddr),
        .in_win  (in_win),
        .tempselx(tempselx)
    );

    assign accept_nonseq = hreadyin && (htrans == HTRANS_NONSEQ);
    assign accept_seq    = hreadyin && (htrans == HTRANS_SEQ);
    assign active_phase  = accept_nonseq || accept_seq;
    assign hrdata        = prdata;

    // Free-running delay line; stalls are handled downstream by the APB FSM
    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr_1      <= '0;
            haddr_2      <= '0;
            hwdata_1     <= '0;
            hwdata_2     <= '0;
            hwrite_reg   <= 1'b0;
            hwrite_reg_1 <= 1'b0;
        end else begin
            haddr_1      <= haddr;
            haddr_2      <= haddr_1;
            hwdata_1     <= hwdata;
            hwdata_2     <= hwdata_1;
            hwrite_reg   <= hwrite;
            hwrite_reg_1 <= hwrite_reg;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            beat_cnt <= '0;
        end else if (accept_nonseq) begin
            beat_cnt <= 5'd1;
        end else if (accept_seq && (beat_cnt != BEAT_CNT_MAX)) begin
            beat_cnt <= beat_cnt + 5'd1;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    resp_state_e state;
    resp_state_e next_state;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= RESP_OK;
        end else begin
            state <= next_state;
        end
    end

    // Error response is a fixed two-cycle sequence; address phases during it are ignored
    always_comb begin
        next_state = state;
        hresp      = HRESP_OKAY;
        err_stall  = 1'b0;
        case (state)
            RESP_OK: begin
                if (active_phase && !in_win) begin
                    next_state = RESP_ERR1;
                end
            end
            RESP_ERR1: begin
                hresp      = HRESP_ERROR;
                err_stall  = 1'b1;
                next_state = RESP_ERR2;
            end
            RESP_ERR2: begin
                hresp      = HRESP_ERROR;
                next_state = RESP_OK;
            end
            default: begin
                next_state = RESP_OK;
            end
        endcase
    end

    assign valid = active_phase && in_win && (state == RESP_OK);
`else
    assign hresp     = HRESP_OKAY;
    assign err_stall = 1'b0;
    assign valid     = active_phase && in_win;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus randomized traffic vs a reference model.
module tb_ahb_slave_if;

    localparam longint unsigned TB_BASE  = 64'h8000_0000;
    localparam longint unsigned TB_SLOT  = 64'h0400_0000;
    localparam longint unsigned TB_NUM   = 64'd3;
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] haddr_1;
    logic [31:0] haddr_2;
    logic [31:0] hwdata_1;
    logic [31:0] hwdata_2;
    logic        hwrite_reg;
    logic        hwrite_reg_1;
    logic [2:0]  tempselx;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        err_stall;
    logic [4:0]  beat_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w1, m_w2;
    int          m_beat;
    int          m_err;

    ahb_slave_if dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hwrite      (hwrite),
        .hreadyin    (hreadyin),
        .htrans      (htrans),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .prdata      (prdata),
        .valid       (valid),
        .haddr_1     (haddr_1),
        .haddr_2     (haddr_2),
        .hwdata_1    (hwdata_1),
        .hwdata_2    (hwdata_2),
        .hwrite_reg  (hwrite_reg),
        .hwrite_reg_1(hwrite_reg_1),
        .tempselx    (tempselx),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .err_stall   (err_stall),
        .beat_cnt    (beat_cnt)
    );

    always #5 hclk = ~hclk;

    function automatic bit m_in_win(input logic [31:0] a);
        longint unsigned x = 64'(a);
        return (x >= TB_BASE) && (x < TB_BASE + TB_NUM * TB_SLOT);
    endfunction

    function automatic logic [2:0] m_sel(input logic [31:0] a);
        longint unsigned x = 64'(a);
        if (!m_in_win(a)) return 3'b000;
        return 3'(64'd1 << ((x - TB_BASE) / TB_SLOT));
    endfunction

    function automatic bit m_valid();
        return hreadyin && (htrans >= 2'd2) && m_in_win(haddr) && (m_err == 0);
    endfunction

    // Advance one clock edge, updating the model from the inputs present at that edge
    task automatic step();
        @(posedge hclk);
        if (hreset) begin
            m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
            m_w1 = 1'b0; m_w2 = 1'b0;
            m_beat = 0; m_err = 0;
        end else begin
            m_a2 = m_a1; m_a1 = haddr;
            m_d2 = m_d1; m_d1 = hwdata;
            m_w2 = m_w1; m_w1 = hwrite;
            if (hreadyin && htrans == 2'd2) m_beat = 1;
            else if (hreadyin && htrans == 2'd3 && m_beat < 31) m_beat = m_beat + 1;
            if (ERR_EN) begin
                if (m_err > 0) m_err = m_err - 1;
                else if (hreadyin && htrans >= 2'd2 && !m_in_win(haddr)) m_err = 2;
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        hreadyin = 1'b1;
        htrans   = 2'd0;
        hwrite   = 1'b0;
    endtask

    task automatic test_reset();
        hreset = 1'b1; hwrite = 1'b0; hreadyin = 1'b0; htrans = 2'd0;
        haddr = '0; hwdata = '0; prdata = '0;
        step();
        step();
        hreset = 1'b0;
        #1;
        checks++;
        if ({haddr_1, haddr_2, hwdata_1, hwdata_2} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_pipe: got %h %h %h %h expected all 0", haddr_1, haddr_2, hwdata_1, hwdata_2);
        end
        checks++;
        if ({hwrite_reg, hwrite_reg_1, valid, tempselx, err_stall} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got wr=%b%b valid=%b sel=%b stall=%b expected 0", hwrite_reg, hwrite_reg_1, valid, tempselx, err_stall);
        end
        checks++;
        if (hresp !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_hresp: got %0d expected 0", hresp);
        end
        checks++;
        if (beat_cnt !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_beat: got %0d expected 0", beat_cnt);
        end
    endtask

    task automatic test_single_write();
        hreadyin = 1'b1; htrans = 2'd2; hwrite = 1'b1;
        haddr = 32'h8000_0000; hwdata = 32'h24;
        #1;
        checks++;
        if (valid !== 1'b1) begin
            errors++; $display("[TB] FAIL write_valid: got %b expected 1", valid);
        end
        checks++;
        if (tempselx !== 3'b001) begin
            errors++; $display("[TB] FAIL write_sel: got %b expected 001", tempselx);
        end
        step();
        drive_idle();
        checks++;
        if ({haddr_1, hwrite_reg, hwdata_1} !== {32'h8000_0000, 1'b1, 32'h24}) begin
            errors++; $display("[TB] FAIL write_stage1: got %h %b %h expected 80000000 1 00000024", haddr_1, hwrite_reg, hwdata_1);
        end
        step();
        checks++;
        if ({haddr_2, hwrite_reg_1, hwdata_1, hwdata_2} !== {32'h8000_0000, 1'b1, 32'h24, 32'h24}) begin
            errors++; $display("[TB] FAIL write_stage2: got %h %b %h %h expected 80000000 1 00000024 00000024", haddr_2, hwrite_reg_1, hwdata_1, hwdata_2);
        end
    endtask

    task automatic test_incr4_read();
        hreadyin = 1'b1; hwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            htrans = (i == 0) ? 2'd2 : 2'd3;
            haddr  = 32'h8400_0000 + 32'(i);
            #1;
            checks++;
            if (tempselx !== 3'b010 || valid !== 1'b1) begin
                errors++; $display("[TB] FAIL incr4_sel beat %0d: got sel=%b valid=%b expected 010 1", i, tempselx, valid);
            end
            step();
            checks++;
            if (beat_cnt !== 5'(i + 1) || hwrite_reg !== 1'b0) begin
                errors++; $display("[TB] FAIL incr4_beat: got cnt=%0d wr=%b expected %0d 0", beat_cnt, hwrite_reg, i + 1);
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_not_ready();
        hreadyin = 1'b0; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h8800_0000;
        #1;
        checks++;
        if (valid !== 1'b0 || tempselx !== 3'b100) begin
            errors++; $display("[TB] FAIL notready_comb: got valid=%b sel=%b expected 0 100", valid, tempselx);
        end
        step();
        checks++;
        if (beat_cnt !== 5'd4 || hresp !== 2'd0) begin
            errors++; $display("[TB] FAIL notready_hold: got cnt=%0d hresp=%0d expected 4 0", beat_cnt, hresp);
        end
        drive_idle();
        step();
    endtask

    task automatic test_out_of_range();
        hreadyin = 1'b1; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h8C00_0000;
        #1;
        checks++;
        if (valid !== 1'b0 || tempselx !== 3'b000) begin
            errors++; $display("[TB] FAIL oor_comb: got valid=%b sel=%b expected 0 000", valid, tempselx);
        end
        step();
        drive_idle();
        checks++;
        if (hresp !== 2'(ERR_EN) || err_stall !== ERR_EN) begin
            errors++; $display("[TB] FAIL oor_err1: got hresp=%0d stall=%b expected %0d %b", hresp, err_stall, ERR_EN, ERR_EN);
        end
        step();
        checks++;
        if (hresp !== 2'(ERR_EN) || err_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL oor_err2: got hresp=%0d stall=%b expected %0d 0", hresp, err_stall, ERR_EN);
        end
        step();
        checks++;
        if (hresp !== 2'd0 || err_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL oor_done: got hresp=%0d stall=%b expected 0 0", hresp, err_stall);
        end
    endtask

    task automatic test_boundary();
        hreadyin = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h8BFF_FFFF;
        #1;
        checks++;
        if (valid !== 1'b1 || tempselx !== 3'b100) begin
            errors++; $display("[TB] FAIL edge_top: got valid=%b sel=%b expected 1 100", valid, tempselx);
        end
        step();
        haddr = 32'h7FFF_FFFF;
        #1;
        checks++;
        if (valid !== 1'b0 || tempselx !== 3'b000) begin
            errors++; $display("[TB] FAIL edge_below: got valid=%b sel=%b expected 0 000", valid, tempselx);
        end
        step();
        drive_idle();
        checks++;
        if (hresp !== 2'(ERR_EN)) begin
            errors++; $display("[TB] FAIL edge_below_resp: got %0d expected %0d", hresp, ERR_EN);
        end
        step();
        step();
        checks++;
        if (hresp !== 2'd0) begin
            errors++; $display("[TB] FAIL edge_recover: got %0d expected 0", hresp);
        end
    endtask

    task automatic test_reset_in_err();
        hreadyin = 1'b1; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h0000_1000;
        step();
        drive_idle();
        checks++;
        if (hresp !== 2'(ERR_EN) || err_stall !== ERR_EN) begin
            errors++; $display("[TB] FAIL rst_err_enter: got hresp=%0d stall=%b expected %0d %b", hresp, err_stall, ERR_EN, ERR_EN);
        end
        hreset = 1'b1; htrans = 2'd3; haddr = 32'hC000_0000;
        step();
        checks++;
        if (hresp !== 2'd0 || err_stall !== 1'b0 || beat_cnt !== 5'd0) begin
            errors++; $display("[TB] FAIL rst_err_clear: got hresp=%0d stall=%b cnt=%0d expected 0 0 0", hresp, err_stall, beat_cnt);
        end
        hreset = 1'b0;
        drive_idle();
        step();
        checks++;
        if (hresp !== 2'd0) begin
            errors++; $display("[TB] FAIL rst_err_after: got %0d expected 0", hresp);
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_addrs [6];
        edge_addrs = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8BFF_FFFF,
                       32'h8C00_0000, 32'h83FF_FFFF, 32'h8400_0000};
        for (int i = 0; i < 400; i++) begin
            hreset   = ($urandom_range(0, 39) == 0);
            hreadyin = ($urandom_range(0, 3) != 0);
            htrans   = 2'($urandom_range(0, 3));
            hwrite   = 1'($urandom);
            hwdata   = $urandom;
            prdata   = $urandom;
            case ($urandom_range(0, 2))
                0:       haddr = 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
                1:       haddr = $urandom;
                default: haddr = edge_addrs[$urandom_range(0, 5)];
            endcase
            #1;
            checks++;
            if (valid !== m_valid() || tempselx !== m_sel(haddr) || hrdata !== prdata) begin
                errors++;
                $display("[TB] FAIL rand_comb @%0d addr=%h: got valid=%b sel=%b rd=%h expected %b %b %h",
                         i, haddr, valid, tempselx, hrdata, m_valid(), m_sel(haddr), prdata);
            end
            step();
            checks++;
            if ({haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg_1} !==
                {m_a1, m_a2, m_d1, m_d2, m_w1, m_w2}) begin
                errors++;
                $display("[TB] FAIL rand_pipe @%0d: got %h %h %h %h %b%b expected %h %h %h %h %b%b",
                         i, haddr_1, haddr_2, hwdata_1, hwdata_2, hwrite_reg, hwrite_reg_1,
                         m_a1, m_a2, m_d1, m_d2, m_w1, m_w2);
            end
            checks++;
            if (beat_cnt !== 5'(m_beat) || hresp !== ((m_err > 0) ? 2'd1 : 2'd0) || err_stall !== (m_err == 2)) begin
                errors++;
                $display("[TB] FAIL rand_state @%0d: got cnt=%0d hresp=%0d stall=%b expected %0d %0d %b",
                         i, beat_cnt, hresp, err_stall, m_beat, (m_err > 0) ? 1 : 0, (m_err == 2));
            end
        end
        hreset = 1'b0;
        drive_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr4_read();
        test_not_ready();
        test_out_of_range();
        test_boundary();
        test_reset_in_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
